// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown timer controller.
// Holds the state encoding, count width and the saturating preset helper.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;

  // Product is formed at 12 bits so the largest preset cannot wrap before saturating.
  function automatic logic [CNT_W-1:0] sat_load(input logic [3:0] units, input logic [11:0] scale);
    logic [11:0] prod;
    prod = {8'd0, units} * scale;
    if (prod > {4'd0, CNT_MAX}) begin
      return CNT_MAX;
    end
    return prod[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/timer_countdown_ctrl_if.sv
// Control/status bundle between the timer controller and its surroundings.
// master drives switches, pulses and alarm_ack; slave (the controller) drives the display/alarm side.
interface timer_countdown_ctrl_if;
  import timer_pkg::*;

  logic [3:0]       timer_set;
  logic             start;
  logic             timer_sw;
  logic             clear;
  logic             alarm_ack;
  logic [CNT_W-1:0] bin_timer_out;
  logic             disp_on;
  logic             expired;
  logic             alarm_req;

  modport master (
    output timer_set, start, timer_sw, clear, alarm_ack,
    input  bin_timer_out, disp_on, expired, alarm_req
  );

  modport slave (
    input  timer_set, start, timer_sw, clear, alarm_ack,
    output bin_timer_out, disp_on, expired, alarm_req
  );

endinterface

// File: rtl/tick_prescaler.sv
// Free-running divider: counts enabled cycles 0..DIV-1 and pulses tick on the wrap cycle.
// Sync clear wins over enable; with enable low the count holds.
module tick_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/timer_countdown_ctrl.sv
// Countdown timer sequencer: preset load, per-tick countdown, pause, expiry blink and alarm handshake.
// Outputs follow inputs by one clock; alarm_req is held until alarm_ack is seen.
module timer_countdown_ctrl
  import timer_pkg::*;
#(
  parameter int TICK_DIV   = 50000000,
  parameter int BLINK_DIV  = 50000000,
  parameter int LOAD_SCALE = 10
) (
  input logic                   CLOCK_50,
  input logic                   reset,
  timer_countdown_ctrl_if.slave bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             disp_on_q, disp_on_d;
  logic             expired_q, expired_d;
  logic             alarm_req_q, alarm_req_d;

  logic [CNT_W-1:0] load_val;
  logic             load_go;
  logic             cnt_tick;
  logic             blink_tick;

  assign load_val = sat_load(bus.timer_set, 12'(LOAD_SCALE));
  assign load_go  = bus.start && (load_val != '0);

  // Held across PAUSE; only clear or a reload restarts the tick phase.
  tick_prescaler #(.DIV(TICK_DIV)) u_cnt_prescaler (
    .clk  (CLOCK_50),
    .rst  (reset),
    .en   ((state_q == ST_RUN) && bus.timer_sw),
    .clr  (bus.clear || load_go),
    .tick (cnt_tick)
  );

  tick_prescaler #(.DIV(BLINK_DIV)) u_blink_prescaler (
    .clk  (CLOCK_50),
    .rst  (reset),
    .en   (state_q == ST_EXPIRED),
    .clr  (state_q != ST_EXPIRED),
    .tick (blink_tick)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    disp_on_d   = disp_on_q;
    expired_d   = expired_q;
    alarm_req_d = alarm_req_q;

    if (bus.clear) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else if (load_go) begin
      count_d = load_val;
      if ((state_q == ST_IDLE) || (state_q == ST_EXPIRED)) begin
        state_d = bus.timer_sw ? ST_RUN : ST_PAUSE;
      end
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (!bus.timer_sw) begin
            state_d = ST_PAUSE;
          end else if (cnt_tick) begin
            if (count_q <= CNT_W'(1)) begin
              count_d     = '0;
              state_d     = ST_EXPIRED;
              alarm_req_d = 1'b1;
              expired_d   = 1'b1;
              disp_on_d   = 1'b1;
            end else begin
              count_d = count_q - CNT_W'(1);
            end
          end
        end
        ST_PAUSE: begin
          if (bus.timer_sw) begin
            state_d = ST_RUN;
          end
        end
        ST_EXPIRED: begin
          if (alarm_req_q && bus.alarm_ack) begin
            alarm_req_d = 1'b0;
          end
          if (blink_tick) begin
            disp_on_d = ~disp_on_q;
          end
        end
        default: ;
      endcase
    end

    // Leaving EXPIRED (or never being in it) restores the quiet display/alarm state.
    if (state_d != ST_EXPIRED) begin
      alarm_req_d = 1'b0;
      expired_d   = 1'b0;
      disp_on_d   = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      disp_on_q   <= 1'b1;
      expired_q   <= 1'b0;
      alarm_req_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      disp_on_q   <= disp_on_d;
      expired_q   <= expired_d;
      alarm_req_q <= alarm_req_d;
    end
  end

  assign bus.bin_timer_out = (state_q == ST_IDLE) ? load_val : count_q;
  assign bus.disp_on       = disp_on_q;
  assign bus.expired       = expired_q;
  assign bus.alarm_req     = alarm_req_q;

endmodule

// File: tb/tb_timer_countdown_ctrl.sv
// Directed bench for timer_countdown_ctrl with a cycle-level behavioural model and literal checkpoints.
module tb_timer_countdown_ctrl;

  localparam int TICK_DIV   = 4;
  localparam int BLINK_DIV  = 3;
  localparam int LOAD_SCALE = 1;
  localparam int SAT_SCALE  = 20;

  localparam int MD_IDLE  = 0;
  localparam int MD_RUN   = 1;
  localparam int MD_PAUSE = 2;
  localparam int MD_EXP   = 3;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  timer_countdown_ctrl_if bus ();
  timer_countdown_ctrl_if bus_s ();

  timer_countdown_ctrl #(
    .TICK_DIV(TICK_DIV), .BLINK_DIV(BLINK_DIV), .LOAD_SCALE(LOAD_SCALE)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus      (bus)
  );

  timer_countdown_ctrl #(
    .TICK_DIV(TICK_DIV), .BLINK_DIV(BLINK_DIV), .LOAD_SCALE(SAT_SCALE)
  ) dut_sat (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus      (bus_s)
  );

  int m_pass = 0, m_total = 0;
  int l_pass = 0, l_total = 0;

  function automatic int lv(input int set, input int scale);
    int p;
    p = set * scale;
    return (p > 255) ? 255 : p;
  endfunction

  // Model: mode, ticks remaining, cycles into current tick period, cycles spent expired, alarm flag.
  int m_mode, m_left, m_phase, m_exp, m_req;
  int nx_mode, nx_left, nx_phase, nx_exp, nx_req;
  int cur_lv;
  int exp_bin, exp_disp, exp_expired, exp_req;

  assign cur_lv = lv(int'(bus.timer_set), LOAD_SCALE);

  always_comb begin
    nx_mode  = m_mode;
    nx_left  = m_left;
    nx_phase = m_phase;
    nx_exp   = m_exp;
    nx_req   = m_req;
    if (bus.clear) begin
      nx_mode = MD_IDLE;
      nx_req  = 0;
    end else if (bus.start && cur_lv > 0) begin
      nx_left  = cur_lv;
      nx_phase = 0;
      nx_req   = 0;
      if (m_mode == MD_IDLE || m_mode == MD_EXP) nx_mode = bus.timer_sw ? MD_RUN : MD_PAUSE;
    end else begin
      case (m_mode)
        MD_RUN: begin
          if (!bus.timer_sw) nx_mode = MD_PAUSE;
          else if (m_phase == TICK_DIV - 1) begin
            nx_phase = 0;
            nx_left  = m_left - 1;
            if (m_left == 1) begin
              nx_mode = MD_EXP;
              nx_exp  = 0;
              nx_req  = 1;
            end
          end else nx_phase = m_phase + 1;
        end
        MD_PAUSE: if (bus.timer_sw) nx_mode = MD_RUN;
        MD_EXP: begin
          nx_exp = m_exp + 1;
          if (m_req != 0 && bus.alarm_ack) nx_req = 0;
        end
        default: ;
      endcase
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode <= MD_IDLE; m_left <= 0; m_phase <= 0; m_exp <= 0; m_req <= 0;
    end else begin
      m_mode <= nx_mode; m_left <= nx_left; m_phase <= nx_phase; m_exp <= nx_exp; m_req <= nx_req;
    end
  end

  always_comb begin
    exp_bin     = (m_mode == MD_IDLE) ? cur_lv : m_left;
    exp_disp    = (m_mode != MD_EXP || ((m_exp / BLINK_DIV) % 2) == 0) ? 1 : 0;
    exp_expired = (m_mode == MD_EXP) ? 1 : 0;
    exp_req     = m_req;
  end

  task automatic mcheck(input string name, input int act, input int exp);
    m_total++;
    if (act == exp) m_pass++;
    else $display("FAIL model_%s @%0t: got %0d expected %0d", name, $time, act, exp);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mcheck("bin", int'(bus.bin_timer_out), exp_bin);
      mcheck("disp_on", int'(bus.disp_on), exp_disp);
      mcheck("expired", int'(bus.expired), exp_expired);
      mcheck("alarm_req", int'(bus.alarm_req), exp_req);
    end
  end

  task automatic lcheck(input string name, input int act, input int exp);
    l_total++;
    if (act == exp) l_pass++;
    else $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    bus.timer_set = 4'd0; bus.start = 1'b0; bus.timer_sw = 1'b0; bus.clear = 1'b0; bus.alarm_ack = 1'b0;
    bus_s.timer_set = 4'd0; bus_s.start = 1'b0; bus_s.timer_sw = 1'b0; bus_s.clear = 1'b0; bus_s.alarm_ack = 1'b0;
    #1 rst = 1'b1;
    #2;
    lcheck("rst_bin", int'(bus.bin_timer_out), 0);
    lcheck("rst_disp", int'(bus.disp_on), 1);
    lcheck("rst_expired", int'(bus.expired), 0);
    lcheck("rst_req", int'(bus.alarm_req), 0);
    cyc(2);
    rst = 1'b0;

    // Saturating preview on the LOAD_SCALE=20 instance
    bus_s.timer_set = 4'd15; #1 lcheck("sat15", int'(bus_s.bin_timer_out), 255);
    bus_s.timer_set = 4'd12; #1 lcheck("sat12", int'(bus_s.bin_timer_out), 240);
    bus_s.timer_set = 4'd13; #1 lcheck("sat13", int'(bus_s.bin_timer_out), 255);
    bus_s.timer_set = 4'd0;  #1 lcheck("sat0",  int'(bus_s.bin_timer_out), 0);

    // Load and count down 3 -> 0
    bus.timer_set = 4'd3; bus.timer_sw = 1'b1;
    #1 lcheck("preview3", int'(bus.bin_timer_out), 3);
    bus.start = 1'b1; cyc(1); bus.start = 1'b0;
    lcheck("load3", int'(bus.bin_timer_out), 3);
    cyc(4); lcheck("cnt2", int'(bus.bin_timer_out), 2);
    cyc(4); lcheck("cnt1", int'(bus.bin_timer_out), 1);
    cyc(3); lcheck("cnt1_hold", int'(bus.bin_timer_out), 1);
    lcheck("not_yet_expired", int'(bus.expired), 0);
    cyc(1);
    lcheck("cnt0", int'(bus.bin_timer_out), 0);
    lcheck("expired_set", int'(bus.expired), 1);
    lcheck("req_set", int'(bus.alarm_req), 1);
    lcheck("disp_entry", int'(bus.disp_on), 1);

    // Blink and alarm handshake (now in expired cycle 0)
    cyc(5);
    lcheck("blink_off_c5", int'(bus.disp_on), 0);
    lcheck("req_held_c5", int'(bus.alarm_req), 1);
    bus.alarm_ack = 1'b1; cyc(1); bus.alarm_ack = 1'b0;
    lcheck("req_drop_c6", int'(bus.alarm_req), 0);
    lcheck("blink_on_c6", int'(bus.disp_on), 1);
    cyc(3);
    lcheck("blink_off_c9", int'(bus.disp_on), 0);
    lcheck("req_stays_low", int'(bus.alarm_req), 0);
    lcheck("still_expired", int'(bus.expired), 1);

    // Start alone in EXPIRED restarts counting
    bus.timer_set = 4'd2; bus.start = 1'b1; cyc(1); bus.start = 1'b0;
    lcheck("restart_bin", int'(bus.bin_timer_out), 2);
    lcheck("restart_expired", int'(bus.expired), 0);
    lcheck("restart_req", int'(bus.alarm_req), 0);
    lcheck("restart_disp", int'(bus.disp_on), 1);

    // Pause mid-period, resume finishes the remaining distance
    cyc(2); bus.timer_sw = 1'b0;
    cyc(10); lcheck("pause_frozen", int'(bus.bin_timer_out), 2);
    bus.timer_sw = 1'b1;
    cyc(2); lcheck("resume_before_tick", int'(bus.bin_timer_out), 2);
    cyc(1); lcheck("resume_tick", int'(bus.bin_timer_out), 1);

    // clear beats start
    bus.timer_set = 4'd5; bus.clear = 1'b1; bus.start = 1'b1; cyc(1);
    bus.clear = 1'b0; bus.start = 1'b0;
    lcheck("prio_bin", int'(bus.bin_timer_out), 5);
    lcheck("prio_disp", int'(bus.disp_on), 1);
    lcheck("prio_expired", int'(bus.expired), 0);
    cyc(3); bus.timer_set = 4'd6;
    #1 lcheck("prio_idle_preview", int'(bus.bin_timer_out), 6);

    // Zero preset start is ignored
    bus.timer_set = 4'd0; bus.start = 1'b1; cyc(1); bus.start = 1'b0;
    cyc(2); lcheck("zero_bin", int'(bus.bin_timer_out), 0);
    bus.timer_set = 4'd4;
    #1 lcheck("zero_stays_idle", int'(bus.bin_timer_out), 4);

    // Start with timer_sw=0 lands in PAUSE; start in PAUSE reloads
    bus.timer_sw = 1'b0; bus.start = 1'b1; cyc(1); bus.start = 1'b0;
    cyc(4); lcheck("pause_load", int'(bus.bin_timer_out), 4);
    bus.timer_set = 4'd7; bus.start = 1'b1; cyc(1); bus.start = 1'b0;
    cyc(2); lcheck("pause_reload", int'(bus.bin_timer_out), 7);
    bus.timer_set = 4'd1;
    #1 lcheck("pause_no_preview", int'(bus.bin_timer_out), 7);

    // Expire from a 1-tick load, then async reset mid-handshake
    bus.clear = 1'b1; cyc(1); bus.clear = 1'b0;
    bus.timer_sw = 1'b1; bus.start = 1'b1; cyc(1); bus.start = 1'b0;
    cyc(4);
    lcheck("one_tick_expired", int'(bus.expired), 1);
    lcheck("one_tick_req", int'(bus.alarm_req), 1);
    #3 rst = 1'b1;
    #1;
    lcheck("arst_req", int'(bus.alarm_req), 0);
    lcheck("arst_expired", int'(bus.expired), 0);
    lcheck("arst_disp", int'(bus.disp_on), 1);
    lcheck("arst_bin", int'(bus.bin_timer_out), 1);
    cyc(1); rst = 1'b0;
    cyc(3);

    $display("%0d/%0d checks passed", m_pass + l_pass, m_total + l_total);
    $finish;
  end

endmodule
